bram_pixel_streamer: RTL and testbench
======================================

// Module: bram_pixel_streamer
// PURPOSE
//  Reads one selected image from bram_images in raster order and streams it to the CNN front end.
//  Sits directly downstream of bram_images: drives its read_en/img_sel/addr and consumes data_out,
//    which has 1-cycle read latency. Emits a valid/ready pixel stream with SOF/EOL/EOF tags.
//  Absorbs BRAM latency under backpressure with a small tagged FIFO and credit-based read issue.
// PARAMETERS
//  NUM_IMAGES    4    images resident in BRAM
//  IMAGE_WIDTH   188  pixels per row
//  IMAGE_HEIGHT  120  rows per image
//  DATA_WIDTH    16   pixel width
//  FIFO_DEPTH    2    output buffer entries; minimum 2, which gives full throughput
// PORTS
//  clk           in   1           single clock, rising edge
//  rst_n         in   1           asynchronous, active-low reset
//  start         in   1           1-cycle request; sampled only in IDLE
//  start_img     in   IMG_SEL_W   image index, latched on accepted start
//  busy          out  1           high from accepted start until done
//  done          out  1           1-cycle pulse after the last beat handshakes
//  bram_read_en  out  1           read strobe to bram_images
//  bram_img_sel  out  IMG_SEL_W   latched image index
//  bram_addr     out  ADDR_W      pixel offset within the image, 0..IMAGE_SIZE-1
//  bram_data     in   DATA_WIDTH  bram_images.data_out; valid 1 cycle after read_en
//  m_valid       out  1           output beat valid
//  m_ready       in   1           downstream accept
//  m_data        out  DATA_WIDTH  pixel
//  m_sof         out  1           first pixel of the image (addr 0)
//  m_eol         out  1           last pixel of a row (col == IMAGE_WIDTH-1)
//  m_eof         out  1           last pixel of the image (addr IMAGE_SIZE-1)
// BEHAVIOUR
//  Reset: all outputs are 0, state is IDLE, FIFO is empty, in-flight count is 0, counters are 0.
//    This holds asynchronously whenever rst_n is low.
//  FSM: IDLE -> RUN on start, latching start_img and clearing addr/col/row.
//    RUN -> DRAIN in the cycle the read of addr IMAGE_SIZE-1 issues.
//    DRAIN -> IDLE once the FIFO is empty, in-flight is 0 and the final pop has occurred.
//    done pulses in the cycle after that final pop.
//  start while busy is ignored. A new start may be accepted in the cycle after done.
//  Issue rule: bram_read_en = (state==RUN) && (fifo_count + inflight - pop < FIFO_DEPTH),
//    where pop = m_valid && m_ready. This is a combinational m_ready -> bram_read_en path.
//  Every issued read increments addr and col. col wraps at IMAGE_WIDTH-1 and increments row.
//  inflight is 1 in the cycle after an issue. The tags {sof,eol,eof} are computed at issue time
//    and delayed 1 cycle alongside the read.
//  FIFO write: on the cycle after an issue, {bram_data, tags} is written. Simultaneous push and pop
//    is legal; count is unchanged.
//  m_valid = !fifo_empty. m_data and the tags come from the FIFO head.
//    They are held stable while m_valid && !m_ready.
//  Latency: first m_valid is high 2 cycles after the edge that samples start.
//    With m_ready held 1, one beat per cycle thereafter: IMAGE_SIZE beats, no bubbles.
//  Overflow is impossible by the credit rule. Underflow is impossible because pop needs m_valid.
//  Reset mid-frame: the in-flight read data is discarded, the FIFO is flushed, and no done is given.
//  Widths: IMAGE_SIZE = W*H = 22560, ADDR_W = $clog2(IMAGE_SIZE) = 15,
//    IMG_SEL_W = $clog2(NUM_IMAGES) = 2, row/col use $clog2 of H/W.
// STRUCTURE
//  Package cnn_img_pkg: IMAGE_SIZE, ADDR_W, IMG_SEL_W, COL_W, ROW_W localparams;
//    typedef enum logic [1:0] {IDLE, RUN, DRAIN} stream_state_t; typedef struct pixel_beat_t
//    {data, sof, eol, eof}.
//  One sub-module, pixel_fifo: synchronous FIFO of pixel_beat_t, parameter DEPTH,
//    same async reset, outputs count/empty/full.
//  Top contains the FSM, addr/row/col counters, the inflight flag and the tag pipeline register.
// TESTING (bench pairs the streamer with bram_images; memory word k = k mod 65536,
//   k = img*22560 + addr)
//  1. start img0, m_ready=1 -> first m_valid 2 cycles later with data 0x0000 and sof.
//     Beat 187 has eol. 22560 back-to-back beats; last = 0x581F with eol+eof; done pulses once.
//  2. start img1, m_ready random 50% -> 22560 beats in order from 0x5820, none lost or duplicated.
//     m_data and tags are stable while stalled. Exactly 120 eol.
//  3. img2, m_ready low for 20 cycles at beat 100 -> at most FIFO_DEPTH reads issued after the stall.
//     bram_read_en stays 0 while full. Stream resumes with beat 100 = 0xB0A4.
//  4. start img3, plus an extra start pulse while busy -> the extra start is ignored.
//     Last beat 0x607F with eof; done then IDLE. A start in the next cycle is accepted.
//  5. rst_n low asynchronously at beat 500 of img0 -> all outputs 0 immediately; no done.
//     After release, start img2 -> first beat 0xB040 with sof.

Source files
------------

// File: rtl/bram_pixel_streamer_pkg.sv
// Shared geometry, FSM state and beat types for the BRAM pixel streamer.
// The geometry constants describe the default 188x120, 4-image, 16-bit configuration.
package cnn_img_pkg;

    localparam int NUM_IMAGES_DEF   = 4;
    localparam int IMAGE_WIDTH_DEF  = 188;
    localparam int IMAGE_HEIGHT_DEF = 120;
    localparam int PIX_W            = 16;

    localparam int IMAGE_SIZE = IMAGE_WIDTH_DEF * IMAGE_HEIGHT_DEF;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);
    localparam int IMG_SEL_W  = $clog2(NUM_IMAGES_DEF);
    localparam int COL_W      = $clog2(IMAGE_WIDTH_DEF);
    localparam int ROW_W      = $clog2(IMAGE_HEIGHT_DEF);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } stream_state_t;

    typedef struct packed {
        logic [PIX_W-1:0] data;
        logic             sof;
        logic             eol;
        logic             eof;
    } pixel_beat_t;

endpackage

// File: rtl/bram_pixel_streamer_if.sv
// Valid/ready pixel stream carrying SOF/EOL/EOF tags.
interface bram_pixel_streamer_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
    logic                  eof;

    modport master (output valid, data, sof, eol, eof, input ready);
    modport slave  (input valid, data, sof, eol, eof, output ready);
endinterface

// File: rtl/bram_pixel_streamer_fifo.sv
// Small synchronous FIFO of tagged pixel beats; head is visible on dout whenever not empty.
// Storage is not reset; only pointers and occupancy are.
module pixel_fifo
    import cnn_img_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  pixel_beat_t                  din,
    input  logic                         pop,
    output pixel_beat_t                  dout,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    pixel_beat_t      mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             wr_en;
    logic             rd_en;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign dout  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= next_ptr(wr_ptr);
            if (rd_en) rd_ptr <= next_ptr(rd_ptr);
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_pixel_streamer.sv
// Streams one image from bram_images in raster order as a tagged valid/ready pixel stream.
// Reads are issued only against free FIFO credit, so the 1-cycle BRAM latency never overflows.
module bram_pixel_streamer
    import cnn_img_pkg::*;
#(
    parameter int NUM_IMAGES   = 4,
    parameter int IMAGE_WIDTH  = 188,
    parameter int IMAGE_HEIGHT = 120,
    parameter int DATA_WIDTH   = 16,
    parameter int FIFO_DEPTH   = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic [$clog2(NUM_IMAGES)-1:0] start_img,
    output logic                          busy,
    output logic                          done,
    output logic                          bram_read_en,
    output logic [$clog2(NUM_IMAGES)-1:0] bram_img_sel,
    output logic [ADDR_W-1:0]             bram_addr,
    input  logic [DATA_WIDTH-1:0]         bram_data,
    bram_pixel_streamer_if.master         m
);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    stream_state_t    state;
    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;
    logic             inflight_p1;
    logic             sof_p1;
    logic             eol_p1;
    logic             eof_p1;

    logic             issue;
    logic             pop;
    logic             is_sof;
    logic             is_eol;
    logic             is_eof;
    logic [CNT_W:0]   credit;
    pixel_beat_t      push_beat;
    pixel_beat_t      head;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_empty;
    logic             fifo_full;

    assign is_sof = (bram_addr == '0);
    assign is_eol = (col == COL_W'(IMAGE_WIDTH - 1));
    assign is_eof = is_eol && (row == ROW_W'(IMAGE_HEIGHT - 1));

    // Credit counts the head being popped this cycle as already free, hence the ready->read_en path.
    assign pop          = m.valid && m.ready;
    assign credit       = {1'b0, fifo_count} + (CNT_W+1)'(inflight_p1) - (CNT_W+1)'(pop);
    assign issue        = (state == RUN) && !(fifo_full && !pop)
                          && (credit < (CNT_W+1)'(FIFO_DEPTH));
    assign bram_read_en = issue;
    assign busy         = (state != IDLE);

    assign push_beat = '{data: PIX_W'(bram_data), sof: sof_p1, eol: eol_p1, eof: eof_p1};

    pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_p1),
        .din   (push_beat),
        .pop   (pop),
        .dout  (head),
        .count (fifo_count),
        .empty (fifo_empty),
        .full  (fifo_full)
    );

    assign m.valid = !fifo_empty;
    assign m.data  = fifo_empty ? '0 : DATA_WIDTH'(head.data);
    assign m.sof   = head.sof && !fifo_empty;
    assign m.eol   = head.eol && !fifo_empty;
    assign m.eof   = head.eof && !fifo_empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            done         <= 1'b0;
            bram_img_sel <= '0;
            bram_addr    <= '0;
            col          <= '0;
            row          <= '0;
            inflight_p1  <= 1'b0;
            sof_p1       <= 1'b0;
            eol_p1       <= 1'b0;
            eof_p1       <= 1'b0;
        end else begin
            // stage p1: read data returns from BRAM alongside these tags
            done        <= 1'b0;
            inflight_p1 <= issue;
            sof_p1      <= is_sof;
            eol_p1      <= is_eol;
            eof_p1      <= is_eof;

            case (state)
                IDLE: begin
                    if (start) begin
                        state        <= RUN;
                        bram_img_sel <= start_img;
                        bram_addr    <= '0;
                        col          <= '0;
                        row          <= '0;
                    end
                end
                RUN: begin
                    if (issue) begin
                        bram_addr <= bram_addr + 1'b1;
                        if (is_eol) begin
                            col <= '0;
                            row <= row + 1'b1;
                        end else begin
                            col <= col + 1'b1;
                        end
                        if (is_eof) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (pop && (fifo_count == CNT_W'(1)) && !inflight_p1) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bram_pixel_streamer.sv
// Directed bench: bram_pixel_streamer paired with a bram_images model (word k = k mod 65536).
module tb_bram_pixel_streamer;
    import cnn_img_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 start;
    logic [IMG_SEL_W-1:0] start_img;
    logic                 busy;
    logic                 done;
    logic                 bram_read_en;
    logic [IMG_SEL_W-1:0] bram_img_sel;
    logic [ADDR_W-1:0]    bram_addr;
    logic [15:0]          bram_data = 16'h0;

    bram_pixel_streamer_if #(.DATA_WIDTH(16)) s_if ();

    bram_pixel_streamer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .start_img    (start_img),
        .busy         (busy),
        .done         (done),
        .bram_read_en (bram_read_en),
        .bram_img_sel (bram_img_sel),
        .bram_addr    (bram_addr),
        .bram_data    (bram_data),
        .m            (s_if)
    );

    always #5 clk = ~clk;

    // bram_images: 1-cycle read latency, word k = img*IMAGE_SIZE + addr
    always @(posedge clk) begin
        if (bram_read_en)
            bram_data <= 16'(32'(bram_img_sel) * 32'(IMAGE_SIZE) + 32'(bram_addr));
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp)
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        else
            n_pass++;
    endtask

    // per-frame observations
    int beats, data_err, tag_err, stab_err, credit_err, busy_err, eol_cnt, done_cnt;
    int first_k, last_k, stall_reads, timed_out;
    logic [15:0] first_data, last_data, b100_data;
    logic        first_sof, b187_eol, last_eol, last_eof, last_stall_ren;

    // mode 0: ready held 1; mode 1: ready random; mode 2: ready low 20 cycles at beat 100
    task automatic run_frame(input int img, input int mode, input int max_beats, input int xstart_at);
        int          k, stall_n, issued, popped;
        logic        pop, hold, xs_done;
        logic [15:0] exp_d, hold_d;
        logic [2:0]  hold_t, cur_t, exp_t;
        beats = 0; data_err = 0; tag_err = 0; stab_err = 0; credit_err = 0; busy_err = 0;
        eol_cnt = 0; done_cnt = 0; first_k = -1; last_k = -1; stall_reads = 0; timed_out = 0;
        first_data = 16'hDEAD; last_data = 16'hDEAD; b100_data = 16'hDEAD;
        first_sof = 0; b187_eol = 0; last_eol = 0; last_eof = 0; last_stall_ren = 1;
        k = 0; stall_n = 0; issued = 0; popped = 0; hold = 0; xs_done = 0;
        hold_d = '0; hold_t = '0;
        @(posedge clk); #1;
        start = 1'b1; start_img = IMG_SEL_W'(img);
        while (beats < max_beats && k < 70000) begin
            @(posedge clk); #1;
            k++;
            start = 1'b0;
            if (xstart_at >= 0 && beats >= xstart_at && !xs_done) begin
                start = 1'b1; start_img = '0; xs_done = 1;
            end
            case (mode)
                1:       s_if.ready = 1'($urandom_range(0, 1));
                2: begin
                    if (beats == 100 && stall_n < 20) begin
                        s_if.ready = 1'b0; stall_n++;
                    end else s_if.ready = 1'b1;
                end
                default: s_if.ready = 1'b1;
            endcase
            #1;
            pop   = s_if.valid && s_if.ready;
            cur_t = {s_if.sof, s_if.eol, s_if.eof};
            if (hold && (!s_if.valid || s_if.data !== hold_d || cur_t !== hold_t)) stab_err++;
            hold = s_if.valid && !s_if.ready; hold_d = s_if.data; hold_t = cur_t;
            if (bram_read_en && (issued - popped - int'(pop)) >= 2) credit_err++;
            if (bram_read_en) issued++;
            if (mode == 2 && !s_if.ready) begin
                if (bram_read_en) stall_reads++;
                last_stall_ren = bram_read_en;
            end
            if (done) done_cnt++;
            if (!busy) busy_err++;
            if (pop) begin
                exp_d = 16'(img * IMAGE_SIZE + beats);
                exp_t = {beats == 0, (beats % 188) == 187, beats == IMAGE_SIZE - 1};
                if (s_if.data !== exp_d) data_err++;
                if (cur_t !== exp_t) tag_err++;
                if (s_if.eol) eol_cnt++;
                if (beats == 0) begin first_k = k; first_data = s_if.data; first_sof = s_if.sof; end
                if (beats == 100) b100_data = s_if.data;
                if (beats == 187) b187_eol = s_if.eol;
                last_k = k; last_data = s_if.data; last_eol = s_if.eol; last_eof = s_if.eof;
                beats++; popped++;
            end
        end
        start = 1'b0;
        if (k >= 70000) timed_out = 1;
    endtask

    task automatic check_done(input string tag);
        @(posedge clk); #2;
        check({tag, " done pulse"}, {31'b0, done}, 32'd1);
        check({tag, " idle at done"}, {31'b0, busy}, 32'd0);
        @(posedge clk); #2;
        check({tag, " done single"}, {31'b0, done}, 32'd0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, " valid"}, {31'b0, s_if.valid}, 32'd0);
        check({tag, " data"}, {16'b0, s_if.data}, 32'd0);
        check({tag, " tags"}, {29'b0, s_if.sof, s_if.eol, s_if.eof}, 32'd0);
        check({tag, " busy/done"}, {30'b0, busy, done}, 32'd0);
        check({tag, " read_en"}, {31'b0, bram_read_en}, 32'd0);
        check({tag, " addr/sel"}, {15'b0, bram_img_sel, bram_addr}, 32'd0);
    endtask

    // asserts reset between edges and checks outputs clear before the next edge
    task automatic async_reset(input string tag);
        #1 rst_n = 1'b0;
        #1 check_outputs_zero(tag);
        repeat (2) begin
            @(posedge clk); #2;
            check({tag, " no done"}, {31'b0, done}, 32'd0);
        end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; start_img = '0; s_if.ready = 1'b0;
        repeat (2) @(posedge clk);
        #2 check_outputs_zero("reset");
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // 1: image 0, continuous ready
        run_frame(0, 0, IMAGE_SIZE, -1);
        check("t1 timeout", timed_out, 0);
        check("t1 first latency", first_k, 3);
        check("t1 first data", {16'b0, first_data}, 32'h0000);
        check("t1 first sof", {31'b0, first_sof}, 32'd1);
        check("t1 beat187 eol", {31'b0, b187_eol}, 32'd1);
        check("t1 data errors", data_err, 0);
        check("t1 tag errors", tag_err, 0);
        check("t1 no bubbles", last_k, IMAGE_SIZE + 2);
        check("t1 last data", {16'b0, last_data}, 32'h581F);
        check("t1 last eol/eof", {30'b0, last_eol, last_eof}, 32'd3);
        check("t1 eol count", eol_cnt, 120);
        check("t1 early done", done_cnt, 0);
        check("t1 credit", credit_err, 0);
        check("t1 busy", busy_err, 0);
        check_done("t1");

        // 2: image 1, random backpressure
        run_frame(1, 1, IMAGE_SIZE, -1);
        check("t2 timeout", timed_out, 0);
        check("t2 first data", {16'b0, first_data}, 32'h5820);
        check("t2 data errors", data_err, 0);
        check("t2 tag errors", tag_err, 0);
        check("t2 stall stability", stab_err, 0);
        check("t2 eol count", eol_cnt, 120);
        check("t2 credit", credit_err, 0);
        check("t2 last data", {16'b0, last_data}, 32'hB03F);
        check("t2 early done", done_cnt, 0);
        check_done("t2");

        // 3: image 2, 20-cycle stall at beat 100, then abort by reset
        run_frame(2, 2, 160, -1);
        check("t3 timeout", timed_out, 0);
        check("t3 beat100", {16'b0, b100_data}, 32'hB0A4);
        check("t3 reads in stall <= 2", {31'b0, stall_reads <= 2}, 32'd1);
        check("t3 read_en off when full", {31'b0, last_stall_ren}, 32'd0);
        check("t3 stall stability", stab_err, 0);
        check("t3 data errors", data_err, 0);
        check("t3 credit", credit_err, 0);
        async_reset("t3 reset");

        // 4: image 3 with a stray start while busy
        run_frame(3, 0, IMAGE_SIZE, 50);
        check("t4 timeout", timed_out, 0);
        check("t4 data errors", data_err, 0);
        check("t4 busy", busy_err, 0);
        check("t4 last data", {16'b0, last_data}, 32'h607F);
        check("t4 last eof", {31'b0, last_eof}, 32'd1);
        check("t4 early done", done_cnt, 0);
        check_done("t4");
        #1 start = 1'b1; start_img = 2'd1;
        @(posedge clk); #1 start = 1'b0;
        #1 check("t4 restart accepted", {31'b0, busy}, 32'd1);
        async_reset("t4 reset");

        // 5: reset at beat 500 of image 0, then image 2
        run_frame(0, 0, 500, -1);
        check("t5 data errors", data_err, 0);
        async_reset("t5 reset");
        repeat (5) begin
            @(posedge clk); #2;
            check("t5 no done after reset", {31'b0, done}, 32'd0);
        end
        run_frame(2, 0, 1, -1);
        check("t5 timeout", timed_out, 0);
        check("t5 first latency", first_k, 3);
        check("t5 first data", {16'b0, first_data}, 32'hB040);
        check("t5 first sof", {31'b0, first_sof}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
